return_addr_stack: RTL

- Parametrised hardware call/return stack for the processor front end.
- Generalises the single-entry function stack to DEPTH entries.
- Adds push, pop and replace operations, occupancy tracking, full/empty status, and sticky overflow/underflow errors.
- Has a selectable full-stack policy: reject the push, or wrap and overwrite the oldest entry.
- Sits beside the PC logic: a call pushes the return address (plus D_WIDTH-IA_WIDTH status bits); a return pops it.

---
 rtl/return_addr_stack_pkg.sv | 20 ++
 rtl/return_addr_stack_regfile.sv | 30 +++
 rtl/return_addr_stack.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/return_addr_stack_pkg.sv
// Shared types and width helpers for the return address stack.
package return_addr_stack_pkg;

    // Operation code, encoded as {push, pop}.
    typedef enum logic [1:0] {
        RAS_NONE    = 2'b00,
        RAS_POP     = 2'b01,
        RAS_PUSH    = 2'b10,
        RAS_REPLACE = 2'b11
    } ras_op_t;

    function automatic int unsigned ras_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned ras_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/return_addr_stack_regfile.sv
// Stack storage: one synchronous write port, two asynchronous read ports.
module stack_regfile
    import return_addr_stack_pkg::*;
#(
    parameter int unsigned D_WIDTH = 34,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [ras_ptr_w(DEPTH)-1:0]   waddr,
    input  logic [D_WIDTH-1:0]            wdata,
    input  logic [ras_ptr_w(DEPTH)-1:0]   raddr_a,
    output logic [D_WIDTH-1:0]            rdata_a,
    input  logic [ras_ptr_w(DEPTH)-1:0]   raddr_b,
    output logic [D_WIDTH-1:0]            rdata_b
);

    logic [D_WIDTH-1:0] mem [DEPTH];

    // Array is intentionally not reset; occupancy tracking guards reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/return_addr_stack.sv
// Parametrised call/return stack with push/pop/replace, occupancy
// tracking and sticky overflow/underflow errors.
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int unsigned IA_WIDTH     = 12,
    parameter int unsigned D_WIDTH      = 34,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned WRAP_ON_FULL = 0
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [D_WIDTH-1:0]           data_i,
    input  logic                         clear_err_i,
    output logic [D_WIDTH-1:0]           data_o,
    output logic [IA_WIDTH-1:0]          ret_addr_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int unsigned PTR_W = ras_ptr_w(DEPTH);
    localparam int unsigned CNT_W = ras_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    ras_op_t            op;
    logic [PTR_W-1:0]   ptr_q, ptr_d, top_ptr, below_ptr, wr_ptr;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [D_WIDTH-1:0] data_q, data_d, rd_top, rd_below;
    logic               ovf_q, ovf_d, unf_q, unf_d;
    logic               empty_q, empty_d, full_q, full_d;
    logic               we, ovf_set, unf_set, is_empty, is_full;

    assign op        = ras_op_t'({push_i, pop_i});
    assign top_ptr   = ptr_q - PTR_W'(1);
    assign below_ptr = ptr_q - PTR_W'(2);
    assign is_empty  = (cnt_q == '0);
    assign is_full   = (cnt_q == CNT_MAX);

    stack_regfile #(
        .D_WIDTH (D_WIDTH),
        .DEPTH   (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .we      (we),
        .waddr   (wr_ptr),
        .wdata   (data_i),
        .raddr_a (top_ptr),
        .rdata_a (rd_top),
        .raddr_b (below_ptr),
        .rdata_b (rd_below)
    );

    // Op decode and next-state; ptr_q always addresses the next free slot.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        we      = 1'b0;
        wr_ptr  = ptr_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        unique case (op)
            RAS_PUSH: begin
                if (!is_full) begin
                    we     = 1'b1;
                    ptr_d  = ptr_q + PTR_W'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                    data_d = data_i;
                end else begin
                    ovf_set = 1'b1;
                    if (WRAP_ON_FULL != 0) begin
                        we     = 1'b1;
                        ptr_d  = ptr_q + PTR_W'(1);
                        data_d = data_i;
                    end
                end
            end
            RAS_POP: begin
                if (!is_empty) begin
                    ptr_d  = top_ptr;
                    cnt_d  = cnt_q - CNT_W'(1);
                    data_d = (cnt_q == CNT_W'(1)) ? '0 : rd_below;
                end else begin
                    unf_set = 1'b1;
                end
            end
            RAS_REPLACE: begin
                we     = 1'b1;
                data_d = data_i;
                if (!is_empty) begin
                    wr_ptr = top_ptr;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        // Set beats a simultaneous clear.
        ovf_d   = ovf_set | (ovf_q & ~clear_err_i);
        unf_d   = unf_set | (unf_q & ~clear_err_i);
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign data_o      = data_q;
    assign ret_addr_o  = data_q[IA_WIDTH-1:0];
    assign count_o     = cnt_q;
    assign empty_o     = empty_q;
    assign full_o      = full_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst_i) begin
            assert (cnt_q <= CNT_MAX) else $error("occupancy above DEPTH");
            assert (!(full_q && empty_q)) else $error("full and empty together");
            assert (empty_q || data_q == rd_top) else $error("data_o differs from stored top");
        end
    end
`endif

endmodule
